// File: rtl/lsu_dcache_arbiter_pkg.sv
// Shared types for the LSU dcache arbiter: arbitration state and in-flight load tag entry.
package lsu_dcache_arbiter_pkg;

  localparam int unsigned LSU_TAG_W = 8;

  typedef enum logic [1:0] {
    StNormal,
    StPrio,
    StDrain
  } lsu_arb_state_e;

  typedef struct packed {
    logic [LSU_TAG_W-1:0] tag;
    logic                 killed;
  } lsu_ld_tag_t;

endpackage

// File: rtl/lsu_dcache_arbiter_if.sv
// Bundle of the load, store, fence, dcache request/response and writeback signals.
// The arbiter connects through the slave modport; the surrounding LSU/dcache use master.
interface lsu_dcache_arbiter_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = lsu_dcache_arbiter_pkg::LSU_TAG_W
);
  logic              ld_valid;
  logic              ld_ready;
  logic [XLEN-1:0]   ld_addr;
  logic [TAG_W-1:0]  ld_tag;
  logic              st_valid;
  logic              st_ready;
  logic [XLEN-1:0]   st_addr;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN/8-1:0] st_wmask;
  logic              squash;
  logic              drain_req;
  logic              drain_done;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_we;
  logic [XLEN-1:0]   dc_req_addr;
  logic [XLEN-1:0]   dc_req_wdata;
  logic [XLEN/8-1:0] dc_req_wmask;
  logic              dc_rsp_valid;
  logic [XLEN-1:0]   dc_rsp_data;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [XLEN-1:0]   wb_data;

  modport slave (
    input  ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_wdata, st_wmask,
    input  squash, drain_req, dc_req_ready, dc_rsp_valid, dc_rsp_data,
    output ld_ready, st_ready, drain_done, dc_req_valid, dc_req_we, dc_req_addr,
    output dc_req_wdata, dc_req_wmask, wb_valid, wb_tag, wb_data
  );

  modport master (
    output ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_wdata, st_wmask,
    output squash, drain_req, dc_req_ready, dc_rsp_valid, dc_rsp_data,
    input  ld_ready, st_ready, drain_done, dc_req_valid, dc_req_we, dc_req_addr,
    input  dc_req_wdata, dc_req_wmask, wb_valid, wb_tag, wb_data
  );

endinterface

// File: rtl/lsu_dcache_arbiter_tag_fifo.sv
// In-order FIFO of in-flight load tags with a kill-all that marks every entry as squashed.
module lsu_dcache_arbiter_tag_fifo
  import lsu_dcache_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [LSU_TAG_W-1:0] i_push_tag,
  input  logic                 i_pop,
  input  logic                 i_kill_all,
  output lsu_ld_tag_t          o_head,
  output logic [PTR_W:0]       o_count,
  output logic                 o_full,
  output logic                 o_empty
);

  lsu_ld_tag_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Killing free slots is harmless: a push always writes killed=0.
      if (i_kill_all) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].killed <= 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{tag: i_push_tag, killed: 1'b0};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // A kill in the same cycle as a pop must already suppress that pop's writeback.
  always_comb begin
    o_head        = r_mem[r_rd_ptr];
    o_head.killed = r_mem[r_rd_ptr].killed | i_kill_all;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Shares the dcache request port between speculative loads and committed stores, with a
// store starvation guard, a drain/fence mode and in-order return of load responses.
module lsu_dcache_arbiter
  import lsu_dcache_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_dcache_arbiter_if.slave   io_bus
);

  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

  lsu_arb_state_e    r_state;
  lsu_arb_state_e    w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_inc;

  logic              w_ld_elig;
  logic              w_grant_ld;
  logic              w_grant_st;
  logic              w_ld_xfer;
  logic              w_st_xfer;
  logic              w_st_blocked;
  logic [XLEN-1:0]   w_req_addr;
  logic [XLEN-1:0]   w_req_wdata;
  logic [XLEN/8-1:0] w_req_wmask;

  lsu_ld_tag_t       w_head;
  logic [PTR_W:0]    w_count;
  logic              w_full;
  logic              w_empty;

  // A response popping this cycle frees the slot the new load will take.
  assign w_ld_elig    = (r_state == StNormal) && (!w_full || io_bus.dc_rsp_valid) &&
                        !io_bus.squash;
  assign w_ld_xfer    = w_grant_ld && io_bus.dc_req_ready;
  assign w_st_xfer    = w_grant_st && io_bus.dc_req_ready;
  assign w_st_blocked = io_bus.st_valid && !w_st_xfer;
  assign w_starve_inc = (r_starve_cnt == STARVE_MAX) ? STARVE_MAX : r_starve_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StNormal;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StNormal: begin
        if (io_bus.drain_req) w_state_nxt = StDrain;
        else if (w_st_blocked && w_starve_inc == STARVE_MAX) w_state_nxt = StPrio;
      end
      StPrio: begin
        if (io_bus.drain_req) w_state_nxt = StDrain;
        else if (w_st_xfer)   w_state_nxt = StNormal;
      end
      StDrain: begin
        if (!io_bus.drain_req) w_state_nxt = StNormal;
      end
      default: w_state_nxt = StNormal;
    endcase
  end

  always_comb begin
    w_grant_ld  = w_ld_elig && io_bus.ld_valid;
    w_grant_st  = !w_grant_ld && io_bus.st_valid;
    w_req_addr  = '0;
    w_req_wdata = '0;
    w_req_wmask = '0;
    if (w_grant_ld) begin
      w_req_addr = io_bus.ld_addr;
    end else if (w_grant_st) begin
      w_req_addr  = io_bus.st_addr;
      w_req_wdata = io_bus.st_wdata;
      w_req_wmask = io_bus.st_wmask;
    end
    io_bus.ld_ready     = w_ld_elig && io_bus.dc_req_ready;
    io_bus.st_ready     = w_grant_st && io_bus.dc_req_ready;
    io_bus.dc_req_valid = w_grant_ld || w_grant_st;
    io_bus.dc_req_we    = w_grant_st;
    io_bus.dc_req_addr  = w_req_addr;
    io_bus.dc_req_wdata = w_req_wdata;
    io_bus.dc_req_wmask = w_req_wmask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_starve_cnt <= '0;
    else if (w_st_xfer)       r_starve_cnt <= '0;
    else if (io_bus.st_valid) r_starve_cnt <= w_starve_inc;
  end

  lsu_dcache_arbiter_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_ld_xfer),
    .i_push_tag (io_bus.ld_tag),
    .i_pop      (io_bus.dc_rsp_valid),
    .i_kill_all (io_bus.squash),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign io_bus.wb_valid   = io_bus.dc_rsp_valid && !w_head.killed;
  assign io_bus.wb_tag     = w_head.tag;
  assign io_bus.wb_data    = io_bus.dc_rsp_data;
  assign io_bus.drain_done = !io_bus.st_valid && (w_count == '0);

  a_rsp_needs_inflight : assert property (@(posedge clk) disable iff (rst)
    io_bus.dc_rsp_valid |-> !w_empty)
    else $error("dc_rsp_valid with no load in flight");

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Directed and randomized bench for lsu_dcache_arbiter against a queue-based reference model.
module tb_lsu_dcache_arbiter;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned MAX_INF = 4;
  localparam int unsigned STARVE  = 8;

  localparam int M_NORMAL = 0;
  localparam int M_PRIO   = 1;
  localparam int M_DRAIN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_dcache_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  lsu_dcache_arbiter #(
    .XLEN         (XLEN),
    .MAX_INFLIGHT (MAX_INF),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: loads in flight in request order, arbitration mode, store wait count.
  typedef struct {
    logic [TAG_W-1:0] tag;
    bit               killed;
  } ent_t;

  ent_t mq[$];
  int   m_mode;
  int   m_wait;
  bit   e_ld_ok;
  bit   e_ld_win;
  bit   e_st_win;

  task automatic model_reset();
    mq.delete();
    m_mode = M_NORMAL;
    m_wait = 0;
  endtask

  task automatic idle();
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.ld_tag       = '0;
    bus.st_valid     = 1'b0;
    bus.st_addr      = '0;
    bus.st_wdata     = '0;
    bus.st_wmask     = '0;
    bus.squash       = 1'b0;
    bus.drain_req    = 1'b0;
    bus.dc_req_ready = 1'b1;
    bus.dc_rsp_valid = 1'b0;
    bus.dc_rsp_data  = '0;
  endtask

  // Called at posedge+1 with inputs applied; samples at the falling edge.
  task automatic eval_cycle();
    bit               room;
    logic [XLEN-1:0]  e_addr;
    #4;
    room     = (mq.size() < MAX_INF) || bus.dc_rsp_valid;
    e_ld_ok  = (m_mode == M_NORMAL) && room && !bus.squash;
    e_ld_win = e_ld_ok && bus.ld_valid;
    e_st_win = !e_ld_win && bus.st_valid;
    e_addr   = e_ld_win ? bus.ld_addr : (e_st_win ? bus.st_addr : '0);
    check_eq("ld_ready", bus.ld_ready, e_ld_ok && bus.dc_req_ready);
    check_eq("st_ready", bus.st_ready, e_st_win && bus.dc_req_ready);
    check_eq("dc_req_valid", bus.dc_req_valid, e_ld_win || e_st_win);
    check_eq("dc_req_we", bus.dc_req_we, e_st_win);
    check_eq("dc_req_addr", bus.dc_req_addr, e_addr);
    check_eq("dc_req_wdata", bus.dc_req_wdata, e_st_win ? bus.st_wdata : '0);
    check_eq("dc_req_wmask", bus.dc_req_wmask, e_st_win ? bus.st_wmask : '0);
    check_eq("drain_done", bus.drain_done, !bus.st_valid && mq.size() == 0);
    if (bus.dc_rsp_valid && mq.size() > 0) begin
      check_eq("wb_valid", bus.wb_valid, !(mq[0].killed || bus.squash));
      check_eq("wb_tag", bus.wb_tag, mq[0].tag);
      check_eq("wb_data", bus.wb_data, bus.dc_rsp_data);
    end else begin
      check_eq("wb_valid_idle", bus.wb_valid, 1'b0);
    end
  endtask

  task automatic tick();
    bit st_xfer;
    bit blocked;
    if (bus.squash) foreach (mq[i]) mq[i].killed = 1'b1;
    if (bus.dc_rsp_valid && mq.size() > 0) mq.delete(0);
    if (e_ld_win && bus.dc_req_ready) mq.push_back('{tag: bus.ld_tag, killed: 1'b0});
    st_xfer = e_st_win && bus.dc_req_ready;
    blocked = bus.st_valid && !st_xfer;
    if (st_xfer) m_wait = 0;
    else if (bus.st_valid && m_wait < STARVE - 1) m_wait++;
    if (m_mode == M_DRAIN) m_mode = bus.drain_req ? M_DRAIN : M_NORMAL;
    else if (bus.drain_req) m_mode = M_DRAIN;
    else if (m_mode == M_NORMAL && blocked && m_wait == STARVE - 1) m_mode = M_PRIO;
    else if (m_mode == M_PRIO && st_xfer) m_mode = M_NORMAL;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval_cycle();
    tick();
  endtask

  task automatic issue_load(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] addr);
    bus.ld_valid = 1'b1;
    bus.ld_tag   = tag;
    bus.ld_addr  = addr;
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic flush_rsp();
    while (mq.size() > 0) begin
      bus.dc_rsp_valid = 1'b1;
      bus.dc_rsp_data  = {$urandom, $urandom};
      step();
    end
    bus.dc_rsp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ld;
    bit got_st;

    // Reset values
    idle();
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_ld_ready", bus.ld_ready, 1'b1);
    check_eq("rst_st_ready", bus.st_ready, 1'b0);
    check_eq("rst_dc_req_valid", bus.dc_req_valid, 1'b0);
    check_eq("rst_wb_valid", bus.wb_valid, 1'b0);
    check_eq("rst_drain_done", bus.drain_done, 1'b1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Load only
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 64'h80;
    bus.ld_tag   = 8'h11;
    eval_cycle();
    check_eq("lo_we", bus.dc_req_we, 1'b0);
    check_eq("lo_addr", bus.dc_req_addr, 64'h80);
    check_eq("lo_valid", bus.dc_req_valid, 1'b1);
    tick();
    idle();
    step();
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'hCAFE;
    eval_cycle();
    check_eq("lo_wb_valid", bus.wb_valid, 1'b1);
    check_eq("lo_wb_tag", bus.wb_tag, 8'h11);
    check_eq("lo_wb_data", bus.wb_data, 64'hCAFE);
    tick();
    idle();

    // Contention: store starves for STARVE-1 load grants, then gets forced through
    n_ld   = 0;
    got_st = 1'b0;
    bus.ld_valid = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h2000;
    bus.st_wdata = 64'h1234_5678_9ABC_DEF0;
    bus.st_wmask = 8'hFF;
    for (int c = 0; c < 20 && !got_st; c++) begin
      bus.ld_tag       = 8'(8'h20 + c);
      bus.ld_addr      = 64'h1000 + 64'(c * 8);
      bus.dc_rsp_valid = (mq.size() > 0);
      bus.dc_rsp_data  = {$urandom, $urandom};
      eval_cycle();
      if (bus.dc_req_valid && bus.dc_req_we) got_st = 1'b1;
      else if (bus.dc_req_valid) n_ld++;
      tick();
    end
    check_eq("cont_ld_grants", n_ld, 7);
    check_eq("cont_st_granted", got_st, 1'b1);
    bus.dc_rsp_valid = (mq.size() > 0);
    bus.ld_tag       = 8'h2F;
    eval_cycle();
    check_eq("cont_ld_resume", bus.dc_req_we, 1'b0);
    check_eq("cont_ld_ready", bus.ld_ready, 1'b1);
    tick();
    idle();
    flush_rsp();

    // Full: MAX_INF loads outstanding blocks the next, a same-cycle response unblocks it
    for (int i = 0; i < MAX_INF; i++) issue_load(8'(8'h30 + i), 64'h3000 + 64'(i));
    bus.ld_valid = 1'b1;
    bus.ld_tag   = 8'h34;
    eval_cycle();
    check_eq("full_ld_ready", bus.ld_ready, 1'b0);
    tick();
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'h5555;
    eval_cycle();
    check_eq("full_pop_ld_ready", bus.ld_ready, 1'b1);
    tick();
    idle();
    flush_rsp();

    // Squash kills everything in flight; later loads return normally
    for (int i = 1; i <= 3; i++) issue_load(8'(i), 64'h4000 + 64'(i));
    bus.squash = 1'b1;
    step();
    bus.squash = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dc_rsp_valid = 1'b1;
      bus.dc_rsp_data  = 64'(i + 100);
      eval_cycle();
      check_eq("sq_wb_valid", bus.wb_valid, 1'b0);
      tick();
    end
    idle();
    issue_load(8'h04, 64'h4100);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'h44;
    eval_cycle();
    check_eq("sq_new_wb_valid", bus.wb_valid, 1'b1);
    check_eq("sq_new_wb_tag", bus.wb_tag, 8'h04);
    tick();
    idle();

    // Drain / fence
    issue_load(8'h40, 64'h5000);
    issue_load(8'h41, 64'h5008);
    bus.drain_req = 1'b1;
    bus.st_valid  = 1'b1;
    bus.st_addr   = 64'h100;
    bus.st_wdata  = 64'hAA;
    bus.st_wmask  = 8'h01;
    eval_cycle();
    check_eq("dr_st_we", bus.dc_req_we, 1'b1);
    check_eq("dr_st_ready", bus.st_ready, 1'b1);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_tag   = 8'h42;
    eval_cycle();
    check_eq("dr_ld_blocked", bus.ld_ready, 1'b0);
    check_eq("dr_no_req", bus.dc_req_valid, 1'b0);
    check_eq("dr_not_done", bus.drain_done, 1'b0);
    tick();
    bus.dc_rsp_valid = 1'b1;
    step();
    step();
    bus.dc_rsp_valid = 1'b0;
    eval_cycle();
    check_eq("dr_done", bus.drain_done, 1'b1);
    check_eq("dr_ld_still_blocked", bus.ld_ready, 1'b0);
    tick();
    bus.drain_req = 1'b0;
    step();
    eval_cycle();
    check_eq("dr_exit_ld_ready", bus.ld_ready, 1'b1);
    check_eq("dr_exit_ld_req", bus.dc_req_valid, 1'b1);
    tick();
    idle();
    flush_rsp();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.ld_valid     = ($urandom_range(0, 99) < 60);
      bus.ld_addr      = {$urandom, $urandom};
      bus.ld_tag       = 8'($urandom);
      bus.st_valid     = ($urandom_range(0, 99) < 50);
      bus.st_addr      = {$urandom, $urandom};
      bus.st_wdata     = {$urandom, $urandom};
      bus.st_wmask     = 8'($urandom);
      bus.dc_req_ready = ($urandom_range(0, 99) < 80);
      bus.squash       = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 3) bus.drain_req = !bus.drain_req;
      bus.dc_rsp_valid = (mq.size() > 0) && ($urandom_range(0, 99) < 40);
      bus.dc_rsp_data  = {$urandom, $urandom};
      step();
    end
    idle();
    step();
    flush_rsp();

    // Async reset with loads in flight
    for (int i = 0; i < 3; i++) issue_load(8'(8'h60 + i), 64'h6000 + 64'(i));
    #2;
    check_eq("ar_pre_drain_done", bus.drain_done, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("ar_ld_ready", bus.ld_ready, 1'b1);
    check_eq("ar_dc_req_valid", bus.dc_req_valid, 1'b0);
    check_eq("ar_wb_valid", bus.wb_valid, 1'b0);
    check_eq("ar_drain_done", bus.drain_done, 1'b1);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    issue_load(8'h77, 64'h7000);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'h7777;
    eval_cycle();
    check_eq("ar_post_wb_tag", bus.wb_tag, 8'h77);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
